// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer: opcodes, ALU codes,
// sequencer state encoding and the control-word payload.
package cpu_sequencer_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPC_W    = 6;
  localparam int unsigned ALU_OP_W = 4;

  localparam logic [OPC_W-1:0] OP_R    = 6'h00;
  localparam logic [OPC_W-1:0] OP_ADDI = 6'h08;
  localparam logic [OPC_W-1:0] OP_LW   = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW   = 6'h2B;
  localparam logic [OPC_W-1:0] OP_BEQ  = 6'h04;
  localparam logic [OPC_W-1:0] OP_HALT = 6'h3F;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'h6;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Control word driven to the datapath and memory each cycle
  typedef struct packed {
    logic                mem_req;
    logic                mem_we;
    logic                mem_src;
    logic                ir_en;
    logic                pc_en;
    logic                pc_sel;
    logic                rf_we;
    logic                rf_src;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> datapath/memory bundle; master is the sequencer side.
interface cpu_sequencer_if #(
  parameter int unsigned CNT_W = 16
) ();
  import cpu_sequencer_pkg::*;

  logic [INSTR_W-1:0]  instr;
  logic                mem_ready;
  logic                alu_zero;
  logic                mem_req;
  logic                mem_we;
  logic                mem_src;
  logic                ir_en;
  logic                pc_en;
  logic                pc_sel;
  logic                rf_we;
  logic                rf_src;
  logic [ALU_OP_W-1:0] alu_op;
  logic                halted;
  logic                err;
  logic                illegal;
  logic [CNT_W-1:0]    retired;

  modport master (
    input  instr, mem_ready, alu_zero,
    output mem_req, mem_we, mem_src, ir_en, pc_en, pc_sel, rf_we, rf_src,
           alu_op, halted, err, illegal, retired
  );

  modport slave (
    output instr, mem_ready, alu_zero,
    input  mem_req, mem_we, mem_src, ir_en, pc_en, pc_sel, rf_we, rf_src,
           alu_op, halted, err, illegal, retired
  );

endinterface

// File: rtl/cpu_sequencer_mem_wait_timer.sv
// Counts consecutive cycles a memory request waits; flags expiry on the
// TIMEOUT-th waiting cycle. TIMEOUT of 0 never expires.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ready,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting_c;

  assign waiting_c = req & ~ready;

  // Saturating count of prior waiting cycles; any non-waiting cycle clears it
  always_comb begin
    cnt_d = '0;
    if (waiting_c) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT != 0) && waiting_c && (cnt_q == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT with
// decoded control outputs, retired-instruction counter and memory timeout.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  cpu_sequencer_if.master bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             err_q, err_d;
  logic             illegal_q, illegal_d;
  logic             retire_c;
  logic             expired_c;
  ctrl_t            ctrl_c, ctrl_o;
  logic [OPC_W-1:0] opcode_c;
  logic [3:0]       funct_c;
  logic             unused_instr_c;

  assign opcode_c       = opcode_of(bus.instr);
  assign funct_c        = bus.instr[3:0];
  assign unused_instr_c = ^bus.instr[25:4];

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (reset),
    .req     (ctrl_o.mem_req),
    .ready   (bus.mem_ready),
    .expired (expired_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      err_q     <= err_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state, control word and flag updates
  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    err_d     = err_q;
    illegal_d = illegal_q;
    retire_c  = 1'b0;
    ctrl_c    = '0;

    case (state_q)
      ST_FETCH: begin
        ctrl_c.mem_req = 1'b1;
        if (bus.mem_ready) begin
          ctrl_c.ir_en = 1'b1;
          ctrl_c.pc_en = 1'b1;
          state_d      = ST_DECODE;
        end
      end

      ST_DECODE: state_d = ST_EXEC;

      ST_EXEC: begin
        case (opcode_c)
          OP_R: begin
            ctrl_c.alu_op = funct_c;
            state_d       = ST_WB;
          end
          OP_ADDI: begin
            ctrl_c.alu_op = ALU_ADD;
            state_d       = ST_WB;
          end
          OP_LW, OP_SW: begin
            ctrl_c.alu_op = ALU_ADD;
            state_d       = ST_MEM;
          end
          OP_BEQ: begin
            ctrl_c.alu_op = ALU_SUB;
            ctrl_c.pc_en  = bus.alu_zero;
            ctrl_c.pc_sel = bus.alu_zero;
            state_d       = ST_FETCH;
            retire_c      = 1'b1;
          end
          OP_HALT: begin
            state_d  = ST_HALT;
            retire_c = 1'b1;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = ST_FETCH;
            retire_c  = 1'b1;
          end
        endcase
      end

      ST_MEM: begin
        ctrl_c.mem_req = 1'b1;
        ctrl_c.mem_src = 1'b1;
        ctrl_c.mem_we  = (opcode_c == OP_SW);
        if (bus.mem_ready) begin
          if (opcode_c == OP_SW) begin
            state_d  = ST_FETCH;
            retire_c = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        ctrl_c.rf_we  = 1'b1;
        ctrl_c.rf_src = (opcode_c == OP_LW);
        state_d       = ST_FETCH;
        retire_c      = 1'b1;
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_FETCH;
    endcase

    // A stalled request that times out aborts the instruction without retiring it
    if (expired_c) begin
      state_d  = ST_HALT;
      err_d    = 1'b1;
      retire_c = 1'b0;
    end

    if (retire_c && (retired_q != '1)) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // Outputs are forced low for as long as reset is held
  assign ctrl_o = reset ? ctrl_c : ctrl_t'('0);

  assign bus.mem_req = ctrl_o.mem_req;
  assign bus.mem_we  = ctrl_o.mem_we;
  assign bus.mem_src = ctrl_o.mem_src;
  assign bus.ir_en   = ctrl_o.ir_en;
  assign bus.pc_en   = ctrl_o.pc_en;
  assign bus.pc_sel  = ctrl_o.pc_sel;
  assign bus.rf_we   = ctrl_o.rf_we;
  assign bus.rf_src  = ctrl_o.rf_src;
  assign bus.alu_op  = ctrl_o.alu_op;
  assign bus.halted  = (state_q == ST_HALT);
  assign bus.err     = err_q;
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus a random
// instruction stream checked against a per-instruction latency/effect model.
module tb_cpu_sequencer;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 15;

  localparam logic [5:0] T_R    = 6'h00;
  localparam logic [5:0] T_ADDI = 6'h08;
  localparam logic [5:0] T_LW   = 6'h23;
  localparam logic [5:0] T_SW   = 6'h2B;
  localparam logic [5:0] T_BEQ  = 6'h04;
  localparam logic [5:0] T_HALT = 6'h3F;
  localparam logic [3:0] T_ADD  = 4'h2;
  localparam logic [3:0] T_SUB  = 4'h6;

  logic clk;
  logic reset;

  cpu_sequencer_if #(.CNT_W(CNT_W)) bus ();

  cpu_sequencer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned exp_retired;
  logic        exp_illegal;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ctrl_vec();
    return {bus.mem_req, bus.mem_we, bus.mem_src, bus.ir_en, bus.pc_en, bus.pc_sel,
            bus.rf_we, bus.rf_src, bus.alu_op};
  endfunction

  // One instruction from FETCH back to FETCH; wf/wm = wait cycles in FETCH/MEM
  task automatic run_instr(input logic [31:0] ins, input logic zero, input int wf, input int wm);
    logic [5:0] op;
    logic [3:0] exp_alu;
    bit is_lw, is_sw, is_mem, is_beq, is_halt, is_ill, writes;
    int lat, ex, n_ir, n_pc, n_rf, n_mwe, n_msrc, n_req;
    op      = ins[31:26];
    is_lw   = (op == T_LW);
    is_sw   = (op == T_SW);
    is_mem  = is_lw || is_sw;
    is_beq  = (op == T_BEQ);
    is_halt = (op == T_HALT);
    is_ill  = !(op inside {T_R, T_ADDI, T_LW, T_SW, T_BEQ, T_HALT});
    writes  = (op == T_R) || (op == T_ADDI) || is_lw;
    exp_alu = (op == T_R) ? ins[3:0] : (is_beq ? T_SUB : T_ADD);
    if (is_beq || is_ill || is_halt) lat = 3;
    else if (is_lw) lat = 5;
    else lat = 4;
    lat = lat + wf + (is_mem ? wm : 0);
    ex  = wf + 2;
    n_ir = 0; n_pc = 0; n_rf = 0; n_mwe = 0; n_msrc = 0; n_req = 0;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      bus.instr     = ins;
      bus.alu_zero  = zero;
      bus.mem_ready = !((k < wf) || ((k >= wf + 3) && (k < wf + 3 + wm)));
      #1;
      if (k == 0) chk("fetch_start", 32'({bus.mem_req, bus.mem_src}), 32'(2'b10));
      if (k == ex && !is_ill && !is_halt) chk("exec_alu_op", 32'(bus.alu_op), 32'(exp_alu));
      if (k == ex && is_beq) chk("beq_pc", 32'({bus.pc_en, bus.pc_sel}), 32'({zero, zero}));
      if (k == lat - 1 && writes) chk("wb_rf", 32'({bus.rf_we, bus.rf_src}), 32'({1'b1, is_lw}));
      n_ir   += int'(bus.ir_en);
      n_pc   += int'(bus.pc_en);
      n_rf   += int'(bus.rf_we);
      n_mwe  += int'(bus.mem_we);
      n_msrc += int'(bus.mem_req && bus.mem_src);
      n_req  += int'(bus.mem_req);
    end
    @(posedge clk);
    #1;
    exp_retired++;
    if (is_ill) exp_illegal = 1'b1;
    chk("cnt_ir_en", 32'(n_ir), 32'd1);
    chk("cnt_pc_en", 32'(n_pc), 32'(1 + ((is_beq && zero) ? 1 : 0)));
    chk("cnt_rf_we", 32'(n_rf), 32'(writes ? 1 : 0));
    chk("cnt_mem_we", 32'(n_mwe), 32'(is_sw ? wm + 1 : 0));
    chk("cnt_mem_alu", 32'(n_msrc), 32'(is_mem ? wm + 1 : 0));
    chk("cnt_mem_req", 32'(n_req), 32'(wf + 1 + (is_mem ? wm + 1 : 0)));
    chk("retired", 32'(bus.retired), 32'(exp_retired));
    chk("illegal", 32'(bus.illegal), 32'(exp_illegal));
    chk("halted", 32'(bus.halted), 32'(is_halt));
    chk("err", 32'(bus.err), 32'd0);
    if (is_halt) chk("halt_ctrl", 32'(ctrl_vec()), 32'd0);
  endtask

  initial begin
    logic [31:0] rnd, ins;
    logic [5:0]  op;
    int          sel;

    reset         = 1'b0;
    bus.instr     = '0;
    bus.mem_ready = 1'b0;
    bus.alu_zero  = 1'b0;
    exp_retired   = 0;
    exp_illegal   = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctrl", 32'(ctrl_vec()), 32'd0);
    chk("rst_flags", 32'({bus.halted, bus.err, bus.illegal}), 32'd0);
    chk("rst_retired", 32'(bus.retired), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Directed scenarios
    run_instr({T_ADDI, 26'h0000123}, 1'b0, 0, 0);
    run_instr({T_LW, 26'h0000040}, 1'b0, 0, 3);
    run_instr({T_BEQ, 26'h0000000}, 1'b1, 0, 0);
    run_instr({T_BEQ, 26'h0000000}, 1'b0, 0, 0);
    run_instr({6'h15, 26'h0000000}, 1'b0, 0, 0);
    run_instr({T_ADDI, 26'h0000001}, 1'b0, 0, 0);
    run_instr({T_SW, 26'h0000008}, 1'b1, 1, 2);
    run_instr({T_R, 26'h000002A}, 1'b0, 2, 0);

    // Random instruction stream
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: op = T_R;
        1: op = T_ADDI;
        2: op = T_LW;
        3: op = T_SW;
        4: op = T_BEQ;
        default: begin
          do begin
            rnd = $urandom();
            op  = rnd[5:0];
          end while (op inside {T_R, T_ADDI, T_LW, T_SW, T_BEQ, T_HALT});
        end
      endcase
      rnd = $urandom();
      ins = {op, rnd[25:0]};
      run_instr(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Fetch stalled until the timeout fires
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      #1;
      if (k == 14) begin
        chk("to_wait_req", 32'(bus.mem_req), 32'd1);
        chk("to_wait_err", 32'(bus.err), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    chk("to_err", 32'(bus.err), 32'd1);
    chk("to_halted", 32'(bus.halted), 32'd1);
    chk("to_retired", 32'(bus.retired), 32'(exp_retired));
    chk("to_ctrl", 32'(ctrl_vec()), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("to_sticky", 32'({bus.err, bus.halted, bus.mem_req}), 32'(3'b110));

    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_retired = 0;
    exp_illegal = 1'b0;
    chk("rst2_flags", 32'({bus.err, bus.halted, bus.illegal}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // HALT, then a reset pulse in the middle of a cycle
    run_instr({T_ADDI, 26'h0000005}, 1'b0, 0, 0);
    run_instr({T_HALT, 26'h0000000}, 1'b0, 1, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("halt_hold", 32'({bus.halted, bus.mem_req}), 32'(2'b10));
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    exp_retired = 0;
    exp_illegal = 1'b0;
    chk("midrst_ctrl", 32'(ctrl_vec()), 32'd0);
    chk("midrst_retired", 32'(bus.retired), 32'd0);
    chk("midrst_halted", 32'(bus.halted), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("resume_fetch", 32'({bus.mem_req, bus.mem_src}), 32'(2'b10));
    run_instr({T_ADDI, 26'h0000007}, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of retired-instruction counter.
REQ-002 SHALL have parameter TIMEOUT, default 15: max cycles mem_req may wait for mem_ready; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port instr  input  32  current instruction register contents; opcode = instr[31:26], funct = instr[5:0].
REQ-006 SHALL have port mem_ready  input  1  shared memory accepted/completed the current request.
REQ-007 SHALL have port alu_zero  input  1  ALU result equals zero.
REQ-008 SHALL have port mem_req, mem_we, mem_src  output  1 each  memory request, write enable, address source (0=PC, 1=ALU).
REQ-009 SHALL have port ir_en, pc_en, pc_sel  output  1 each  IR load, PC load, PC source (0=PC+4, 1=branch target).
REQ-010 SHALL have port rf_we, rf_src  output  1 each  register write, write-data source (0=ALU, 1=memory).
REQ-011 SHALL have port alu_op  output  4  ALU operation code.
REQ-012 SHALL have port halted, err, illegal  output  1 each  halt reached, memory timeout, last opcode unrecognised (sticky).
REQ-013 SHALL have port retired  output  CNT_W  count of retired instructions.

Function
REQ-014 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-015 SHALL drive control outputs combinationally from state and instr (Moore plus opcode decode); flags and counters are registered.
REQ-016 FETCH: mem_req=1, mem_src=0; when mem_ready=1 in the same cycle, pulse ir_en=1 and pc_en=1 (pc_sel=0), go to DECODE; otherwise hold.
REQ-017 DECODE: one cycle, no outputs asserted, go to EXEC.
REQ-018 EXEC: alu_op from decode; R-type (6'h00): alu_op = funct[3:0], go to WB; ADDI (6'h08): alu_op=ADD, go to WB; LW (6'h23)/SW (6'h2B): alu_op=ADD, go to MEM; BEQ (6'h04): alu_op=SUB, pc_en=pc_sel=alu_zero, go to FETCH; HALT (6'h3F): go to HALT; any other opcode: set illegal, go to FETCH (treated as NOP).
REQ-019 MEM: mem_req=1, mem_src=1, mem_we=1 only for SW; on mem_ready SW goes to FETCH, LW goes to WB; otherwise hold with outputs stable.
REQ-020 WB: rf_we=1 for one cycle, rf_src=1 for LW else 0, go to FETCH.
REQ-021 HALT: all control outputs 0, halted=1, remains until reset.
REQ-022 retired SHALL increment by 1 on each transition into FETCH from EXEC, MEM or WB, and on entry to HALT; it saturates at all-ones.
REQ-023 Latency with mem_ready tied high: BEQ/illegal 3 cycles, SW/R-type/ADDI 4 cycles, LW 5 cycles, FETCH to FETCH.
REQ-024 Wait counter SHALL clear on every cycle without a pending mem_req and count while mem_req=1 and mem_ready=0; reaching TIMEOUT (nonzero) sets err and forces HALT the next cycle, without incrementing retired.
REQ-025 mem_req SHALL never be deasserted before mem_ready is sampled high, except on reset or timeout.
REQ-026 illegal and err SHALL be sticky until reset.

Reset
REQ-027 reset low SHALL asynchronously set state=FETCH, retired=0, wait counter=0, err=illegal=halted=0.
REQ-028 While reset is low all outputs SHALL be 0, including mem_req; the first mem_req occurs in the first cycle after deassertion.
REQ-029 Reset asserted mid-MEM or mid-FETCH SHALL abandon the request with no ir_en, pc_en or rf_we pulse.

Structure
REQ-030 Opcode constants (R, ADDI, LW, SW, BEQ, HALT), the ALU op codes ADD/SUB, and the state encoding SHALL live in a shared package used by the datapath and the sequencer.
REQ-031 The wait/timeout counter SHALL be a sub-module mem_wait_timer (inputs: req, ready; output: expired).

Verification
REQ-032 mem_ready=1, instr=ADDI: reset release -> ir_en in cycle 1, alu_op=ADD in cycle 3, rf_we=1 in cycle 4, retired=1 after cycle 4.
REQ-033 LW with mem_ready low for 3 cycles in MEM -> mem_req and mem_src=1 held 4 cycles, then rf_we=1 with rf_src=1, total 8 cycles.
REQ-034 BEQ with alu_zero=1 -> pc_en=pc_sel=1 in EXEC; with alu_zero=0 -> pc_en=0 in EXEC; both retire in 3 cycles.
REQ-035 instr opcode 6'h15 -> illegal=1, retired increments, next FETCH starts; illegal stays 1.
REQ-036 mem_ready held low in FETCH, TIMEOUT=15 -> err=1 and halted=1 after 15 waiting cycles, retired unchanged.
REQ-037 HALT opcode, then reset pulsed low mid-cycle -> outputs 0 immediately, retired=0, FETCH resumes after release.
